// File: rtl/ball_motion_step_if.sv
// Selector <-> ball motion block connection.
// The selector drives the chosen ball state and the frame tick.
// The motion block returns the committed state and the per-step event flags.
interface ball_motion_step_if;
  logic        frame_tick;
  logic [21:0] location_in;
  logic [31:0] velocity_in;
  logic [16:0] angle_in;

  logic [21:0] location_feedback;
  logic [31:0] velocity_feedback;
  logic [16:0] angle_feedback;
  logic        upd_valid;
  logic        busy;
  logic        out_left;
  logic        out_right;
  logic        wall_hit;
  logic        tick_overrun;

  modport master (
    output frame_tick, location_in, velocity_in, angle_in,
    input  location_feedback, velocity_feedback, angle_feedback,
    input  upd_valid, busy, out_left, out_right, wall_hit, tick_overrun
  );

  modport slave (
    input  frame_tick, location_in, velocity_in, angle_in,
    output location_feedback, velocity_feedback, angle_feedback,
    output upd_valid, busy, out_left, out_right, wall_hit, tick_overrun
  );
endinterface

// File: rtl/ball_motion_step.sv
// Ball motion step: on each frame tick, captures the selected ball state,
// integrates one motion step with spin-driven curve, reflects off the
// top/bottom walls, detects left/right exits and commits the result.
module ball_motion_step #(
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479,
  parameter int ANG_SHIFT   = 4,
  parameter int DECAY_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  ball_motion_step_if.slave  bus
);

  localparam logic signed [17:0] XMinS = 18'(X_MIN);
  localparam logic signed [17:0] XMaxS = 18'(X_MAX);
  localparam logic signed [17:0] YMinS = 18'(Y_MIN);
  localparam logic signed [17:0] YMaxS = 18'(Y_MAX);
  localparam logic signed [17:0] Sat16Max = 18'sd32767;
  localparam logic signed [17:0] Sat16Min = -18'sd32768;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    INTEG   = 3'd2,
    CHECK   = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [1:0] rstSync_q;
  logic       rstSyncN;

  logic [10:0]        capX_q, capY_q;
  logic signed [15:0] capVx_q, capVy_q;
  logic signed [16:0] capAng_q;

  logic signed [17:0] intNx_q, intNy_q;
  logic signed [15:0] intVy_q;
  logic signed [16:0] intAng_q;

  logic [21:0] fbLoc_q;
  logic [31:0] fbVel_q;
  logic [16:0] fbAng_q;
  logic        updValid_q, outLeft_q, outRight_q, wallHit_q, tickOverrun_q;

  logic signed [16:0] angStep;
  logic signed [17:0] vyExt, angStepExt, vySum, xExt, vxExt, yExt, vyNewExt;
  logic signed [17:0] nxCalc, nyCalc;
  logic signed [15:0] vyNew;
  logic signed [16:0] angNew;

  logic signed [17:0] ry;
  logic signed [15:0] rvy;
  logic               chkWall, chkLeft, chkRight;
  logic [10:0]        newX, newY;
  logic signed [15:0] newVx, newVy;
  logic signed [16:0] newAng;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > Sat16Max) return 16'sh7fff;
    if (v < Sat16Min) return 16'sh8000;
    return v[15:0];
  endfunction

  // Negation that cannot wrap: the most negative value maps to the most positive.
  function automatic logic signed [15:0] negSat16(input logic signed [15:0] v);
    if (v == 16'sh8000) return 16'sh7fff;
    return -v;
  endfunction

  // Reset synchronizer: assertion is immediate, release lines up with the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstSync_q <= 2'b00;
    else        rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstSyncN = rstSync_q[1];

  // State register for the fixed five-phase step sequence.
  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state: a tick in IDLE starts a step, every other phase advances unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.frame_tick) state_d = CAPTURE;
      CAPTURE: state_d = INTEG;
      INTEG:   state_d = CHECK;
      CHECK:   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One motion step: curve vy by the spin, move, and let the spin decay.
  always_comb begin
    angStep    = capAng_q >>> ANG_SHIFT;
    angStepExt = {angStep[16], angStep};
    vyExt      = {{2{capVy_q[15]}}, capVy_q};
    vySum      = vyExt + angStepExt;
    vyNew      = sat16(vySum);
    xExt       = {7'd0, capX_q};
    vxExt      = {{2{capVx_q[15]}}, capVx_q};
    nxCalc     = xExt + vxExt;
    yExt       = {7'd0, capY_q};
    vyNewExt   = {{2{vyNew[15]}}, vyNew};
    nyCalc     = yExt + vyNewExt;
    angNew     = capAng_q - (capAng_q >>> DECAY_SHIFT);
  end

  // Bounds check: reflect y off the walls (clamping if still outside), stop the ball on an x exit.
  always_comb begin
    ry       = intNy_q;
    rvy      = intVy_q;
    chkWall  = 1'b0;
    chkLeft  = 1'b0;
    chkRight = 1'b0;
    newX     = intNx_q[10:0];
    newVx    = capVx_q;
    newAng   = intAng_q;
    if (intNy_q < YMinS) begin
      ry      = (YMinS <<< 1) - intNy_q;
      rvy     = negSat16(intVy_q);
      chkWall = 1'b1;
    end else if (intNy_q > YMaxS) begin
      ry      = (YMaxS <<< 1) - intNy_q;
      rvy     = negSat16(intVy_q);
      chkWall = 1'b1;
    end
    if (ry < YMinS)      ry = YMinS;
    else if (ry > YMaxS) ry = YMaxS;
    newY  = ry[10:0];
    newVy = rvy;
    if (intNx_q < XMinS) begin
      newX    = XMinS[10:0];
      chkLeft = 1'b1;
    end else if (intNx_q > XMaxS) begin
      newX     = XMaxS[10:0];
      chkRight = 1'b1;
    end
    if (chkLeft || chkRight) begin
      newVx  = 16'sd0;
      newVy  = 16'sd0;
      newAng = 17'sd0;
    end
  end

  // Capture the selector output, then hold the integrated intermediate values for the check phase.
  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      capX_q   <= '0;
      capY_q   <= '0;
      capVx_q  <= '0;
      capVy_q  <= '0;
      capAng_q <= '0;
      intNx_q  <= '0;
      intNy_q  <= '0;
      intVy_q  <= '0;
      intAng_q <= '0;
    end else begin
      if (state_q == CAPTURE) begin
        capX_q   <= bus.location_in[21:11];
        capY_q   <= bus.location_in[10:0];
        capVx_q  <= bus.velocity_in[31:16];
        capVy_q  <= bus.velocity_in[15:0];
        capAng_q <= bus.angle_in;
      end
      if (state_q == INTEG) begin
        intNx_q  <= nxCalc;
        intNy_q  <= nyCalc;
        intVy_q  <= vyNew;
        intAng_q <= angNew;
      end
    end
  end

  // Commit the checked result so feedback and event pulses appear together in the COMMIT cycle.
  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      fbLoc_q       <= '0;
      fbVel_q       <= '0;
      fbAng_q       <= '0;
      updValid_q    <= 1'b0;
      outLeft_q     <= 1'b0;
      outRight_q    <= 1'b0;
      wallHit_q     <= 1'b0;
      tickOverrun_q <= 1'b0;
    end else begin
      updValid_q    <= (state_q == CHECK);
      outLeft_q     <= (state_q == CHECK) && chkLeft;
      outRight_q    <= (state_q == CHECK) && chkRight;
      wallHit_q     <= (state_q == CHECK) && chkWall;
      tickOverrun_q <= bus.frame_tick && (state_q != IDLE);
      if (state_q == CHECK) begin
        fbLoc_q <= {newX, newY};
        fbVel_q <= {newVx, newVy};
        fbAng_q <= newAng;
      end
    end
  end

  assign bus.location_feedback = fbLoc_q;
  assign bus.velocity_feedback = fbVel_q;
  assign bus.angle_feedback    = fbAng_q;
  assign bus.upd_valid         = updValid_q;
  assign bus.busy              = (state_q != IDLE);
  assign bus.out_left          = outLeft_q;
  assign bus.out_right         = outRight_q;
  assign bus.wall_hit          = wallHit_q;
  assign bus.tick_overrun      = tickOverrun_q;

endmodule

// File: tb/tb_ball_motion_step.sv
// Testbench for ball_motion_step: directed steps plus a few random steps,
// expected results queued at stimulus time and compared at upd_valid.
module tb_ball_motion_step;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    int x;
    int y;
    int vx;
    int vy;
    int ang;
    bit left;
    bit right;
    bit wall;
  } exp_t;

  exp_t expQ[$];

  ball_motion_step_if bus ();

  ball_motion_step dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something below stops advancing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic exp_t mk(input int x, input int y, input int vx, input int vy,
                              input int ang, input bit l, input bit r, input bit w);
    exp_t e;
    e.x = x; e.y = y; e.vx = vx; e.vy = vy; e.ang = ang;
    e.left = l; e.right = r; e.wall = w;
    return e;
  endfunction

  // Reference step written from the behavioural description in plain integer math.
  function automatic exp_t modelStep(input int x, input int y, input int vx, input int vy, input int ang);
    exp_t e;
    int nvy, nx, ny, na, nvx;
    e = mk(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    nvy = vy + (ang >>> 4);
    if (nvy > 32767) nvy = 32767;
    else if (nvy < -32768) nvy = -32768;
    nx  = x + vx;
    ny  = y + nvy;
    na  = ang - (ang >>> 3);
    nvx = vx;
    if (ny < 0) begin
      ny = -ny;
      nvy = (nvy == -32768) ? 32767 : -nvy;
      e.wall = 1'b1;
    end else if (ny > 479) begin
      ny = 958 - ny;
      nvy = (nvy == -32768) ? 32767 : -nvy;
      e.wall = 1'b1;
    end
    if (ny < 0) ny = 0;
    else if (ny > 479) ny = 479;
    if (nx < 0) begin
      nx = 0; e.left = 1'b1;
    end else if (nx > 639) begin
      nx = 639; e.right = 1'b1;
    end
    if (e.left || e.right) begin
      nvx = 0; nvy = 0; na = 0;
    end
    e.x = nx; e.y = ny; e.vx = nvx; e.vy = nvy; e.ang = na;
    return e;
  endfunction

  task automatic applyStimulus(input int x, input int y, input int vx, input int vy, input int ang);
    @(negedge clk);
    bus.location_in = {11'(x), 11'(y)};
    bus.velocity_in = {16'(vx), 16'(vy)};
    bus.angle_in    = 17'(ang);
    bus.frame_tick  = 1'b1;
    @(negedge clk);
    bus.frame_tick  = 1'b0;
    checkValue("busy_after_tick", int'(bus.busy), 1);
  endtask

  task automatic compareNow(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checkValue({tag, ".sb_size"}, expQ.size(), 1);
      return;
    end
    e = expQ.pop_front();
    checkValue({tag, ".x"},     int'(bus.location_feedback[21:11]), e.x);
    checkValue({tag, ".y"},     int'(bus.location_feedback[10:0]), e.y);
    checkValue({tag, ".vx"},    int'($signed(bus.velocity_feedback[31:16])), e.vx);
    checkValue({tag, ".vy"},    int'($signed(bus.velocity_feedback[15:0])), e.vy);
    checkValue({tag, ".ang"},   int'($signed(bus.angle_feedback)), e.ang);
    checkValue({tag, ".left"},  int'(bus.out_left), int'(e.left));
    checkValue({tag, ".right"}, int'(bus.out_right), int'(e.right));
    checkValue({tag, ".wall"},  int'(bus.wall_hit), int'(e.wall));
  endtask

  task automatic checkOutput(input string tag);
    int lat = 0;
    int k   = 0;
    while (lat == 0 && k < 20) begin
      k++;
      @(negedge clk);
      if (bus.upd_valid === 1'b1) lat = k;
    end
    checkValue({tag, ".latency"}, lat, 3);
    if (lat != 0) compareNow(tag);
    else if (expQ.size() > 0) void'(expQ.pop_front());
    @(negedge clk);
    checkValue({tag, ".upd_clear"}, int'(bus.upd_valid), 0);
    checkValue({tag, ".busy_clear"}, int'(bus.busy), 0);
  endtask

  task automatic checkResetState(input string tag);
    checkValue({tag, ".loc"},     int'(bus.location_feedback), 0);
    checkValue({tag, ".vel"},     int'(bus.velocity_feedback), 0);
    checkValue({tag, ".ang"},     int'(bus.angle_feedback), 0);
    checkValue({tag, ".upd"},     int'(bus.upd_valid), 0);
    checkValue({tag, ".busy"},    int'(bus.busy), 0);
    checkValue({tag, ".flags"},   int'({bus.out_left, bus.out_right, bus.wall_hit}), 0);
    checkValue({tag, ".overrun"}, int'(bus.tick_overrun), 0);
  endtask

  initial begin
    int updCount, updAt, ovCount;
    int rx, ry, rvx, rvy, rang;

    rst_n           = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.location_in = '0;
    bus.velocity_in = '0;
    bus.angle_in    = '0;

    // A tick while reset is held must be ignored.
    repeat (2) @(negedge clk);
    bus.location_in = {11'd50, 11'd50};
    bus.velocity_in = {16'd3, 16'd3};
    bus.frame_tick  = 1'b1;
    @(negedge clk);
    bus.frame_tick  = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkResetState("post_release");

    // Plain straight-line step.
    expQ.push_back(mk(105, 97, 5, -3, 0, 0, 0, 0));
    applyStimulus(100, 100, 5, -3, 0);
    checkOutput("basic");

    // Reset in the middle of INTEG: no partial commit, nothing after release.
    applyStimulus(300, 300, 1, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkResetState("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkResetState("rst_after");

    // Wall reflections, top then bottom.
    expQ.push_back(mk(200, 4, 0, 6, 0, 0, 0, 1));
    applyStimulus(200, 2, 0, -6, 0);
    checkOutput("wall_top");
    expQ.push_back(mk(200, 476, 0, -5, 0, 0, 0, 1));
    applyStimulus(200, 477, 0, 5, 0);
    checkOutput("wall_bottom");

    // Exact wall positions are in bounds.
    expQ.push_back(mk(10, 479, 0, 9, 0, 0, 0, 0));
    applyStimulus(10, 470, 0, 9, 0);
    checkOutput("y_eq_max");
    expQ.push_back(mk(10, 0, 0, -9, 0, 0, 0, 0));
    applyStimulus(10, 9, 0, -9, 0);
    checkOutput("y_eq_min");

    // Horizontal limits: landing on 639 is fine, passing it exits and stops the ball.
    expQ.push_back(mk(639, 50, 4, 0, 0, 0, 0, 0));
    applyStimulus(635, 50, 4, 0, 0);
    checkOutput("x_eq_max");
    expQ.push_back(mk(639, 56, 0, 0, 0, 0, 1, 0));
    applyStimulus(639, 50, 4, 0, 100);
    checkOutput("exit_right");
    expQ.push_back(mk(0, 50, -5, 0, 0, 0, 0, 0));
    applyStimulus(5, 50, -5, 0, 0);
    checkOutput("x_eq_min");
    expQ.push_back(mk(0, 50, 0, 0, 0, 1, 0, 0));
    applyStimulus(2, 50, -5, 0, 0);
    checkOutput("exit_left");

    // Spin curve and decay, two chained steps, a negative spin and a small spin that holds.
    expQ.push_back(mk(300, 244, 0, 4, 56, 0, 0, 0));
    applyStimulus(300, 240, 0, 0, 64);
    checkOutput("spin1");
    expQ.push_back(mk(300, 251, 0, 7, 49, 0, 0, 0));
    applyStimulus(300, 244, 0, 4, 56);
    checkOutput("spin2");
    expQ.push_back(mk(300, 236, 0, -4, -56, 0, 0, 0));
    applyStimulus(300, 240, 0, 0, -64);
    checkOutput("spin_neg");
    expQ.push_back(mk(51, 51, 1, 1, 7, 0, 0, 0));
    applyStimulus(50, 50, 1, 1, 7);
    checkOutput("spin_small");

    // Overrun: extra ticks during INTEG and during COMMIT, exactly one update.
    expQ.push_back(mk(403, 202, 3, 2, 0, 0, 0, 0));
    @(negedge clk);
    bus.location_in = {11'd400, 11'd200};
    bus.velocity_in = {16'd3, 16'd2};
    bus.angle_in    = 17'd0;
    bus.frame_tick  = 1'b1;
    updCount = 0;
    updAt    = 0;
    ovCount  = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.upd_valid === 1'b1) begin
        updCount++;
        if (updAt == 0) begin
          updAt = k;
          compareNow("ovr");
        end
      end
      if (bus.tick_overrun === 1'b1) ovCount++;
      if (k == 3) checkValue("ovr.overrun_integ", int'(bus.tick_overrun), 1);
      if (k == 5) checkValue("ovr.overrun_commit", int'(bus.tick_overrun), 1);
      bus.frame_tick = (k == 2 || k == 4);
    end
    checkValue("ovr.upd_count", updCount, 1);
    checkValue("ovr.upd_at", updAt, 4);
    checkValue("ovr.overrun_count", ovCount, 2);
    checkValue("ovr.busy_end", int'(bus.busy), 0);

    // Saturation corners.
    expQ.push_back(mk(100, 479, 0, 32767, 0, 0, 0, 1));
    applyStimulus(100, 100, 0, -32768, 0);
    checkOutput("neg_min_vy");
    expQ.push_back(mk(100, 0, 0, -32767, 3584, 0, 0, 1));
    applyStimulus(100, 100, 0, 32767, 4096);
    checkOutput("sat_vy");

    // A few random steps against the reference model.
    for (int i = 0; i < 6; i++) begin
      rx   = int'($urandom_range(639));
      ry   = int'($urandom_range(479));
      rvx  = int'($urandom_range(80)) - 40;
      rvy  = int'($urandom_range(80)) - 40;
      rang = int'($urandom_range(4000)) - 2000;
      expQ.push_back(modelStep(rx, ry, rvx, rvy, rang));
      applyStimulus(rx, ry, rvx, rvy, rang);
      checkOutput($sformatf("rand%0d", i));
    end

    checkValue("sb_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
